// File: rtl/usb_pkg.sv
// Shared USB constants, PID helpers and the transmit sequencer state type.
// Used by the transmit sequencer and the serial CRC16 generator.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    localparam logic [7:0]  SYNC_BYTE  = 8'h80;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_t;

    function automatic logic is_handshake_pid(input logic [3:0] pid);
        return (pid == PID_ACK) || (pid == PID_NAK) || (pid == PID_STALL);
    endfunction

    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

    // Only packets this device may originate are legal on the transmit side.
    function automatic logic is_tx_pid(input logic [3:0] pid);
        return is_handshake_pid(pid) || is_data_pid(pid);
    endfunction

endpackage

// File: rtl/crc16_gen.sv
// Serial CRC16 (poly 0x8005), one data bit per enable; clear reloads the seed.
// Shared by the transmit sequencer and the receive-side checker.
module crc16_gen
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        enable,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic        fb;

    always_comb begin
        crc_d = crc_q;
        fb    = din ^ crc_q[15];
        if (clear) begin
            crc_d = CRC16_INIT;
        end else if (enable) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/usb_tx_ctrl.sv
// USB transmit sequencer: SYNC, PID, optional payload and CRC16, then EOP,
// advancing one bit per encoder bit request and pulling payload from a show-ahead FIFO.
module usb_tx_ctrl
    import usb_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             tx_start,
    input  logic [3:0]       tx_pid,
    input  logic [LEN_W-1:0] tx_len,
    input  logic [7:0]       fifo_rdata,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    input  logic             bit_req,
    output logic             tx_bit,
    output logic             tx_se0,
    output logic             tx_active,
    output logic             tx_done,
    output logic             tx_error
);

    tx_state_t        state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [3:0]       pid_q, pid_d;
    logic [LEN_W-1:0] bytes_left_q, bytes_left_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic             crc_clear;
    logic             crc_en;
    logic [15:0]      crc;
    logic             byte_end;
    logic             load_next;
    logic             len_ok;

    crc16_gen u_crc (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (crc_clear),
        .enable (crc_en),
        .din    (shreg_q[0]),
        .crc    (crc)
    );

    assign byte_end = (bit_cnt_q[2:0] == 3'd7);
    assign len_ok   = !is_data_pid(tx_pid) || (tx_len <= LEN_W'(MAX_LEN));

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        pid_d        = pid_q;
        bytes_left_d = bytes_left_q;
        done_d       = 1'b0;
        error_d      = 1'b0;
        crc_clear    = 1'b0;
        crc_en       = 1'b0;
        fifo_rd      = 1'b0;
        load_next    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    if (is_tx_pid(tx_pid) && len_ok) begin
                        state_d      = ST_SYNC;
                        shreg_d      = SYNC_BYTE;
                        bit_cnt_d    = 4'd0;
                        pid_d        = tx_pid;
                        bytes_left_d = tx_len;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end

            ST_SYNC: begin
                if (bit_req) begin
                    if (byte_end) begin
                        state_d   = ST_PID;
                        shreg_d   = {~pid_q, pid_q};
                        bit_cnt_d = 4'd0;
                        crc_clear = 1'b1;
                    end else begin
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end

            ST_PID: begin
                if (bit_req) begin
                    if (!byte_end) begin
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (is_handshake_pid(pid_q)) begin
                        state_d   = ST_EOP_SE0;
                        bit_cnt_d = 4'd0;
                    end else if (bytes_left_q == '0) begin
                        state_d   = ST_CRC;
                        bit_cnt_d = 4'd0;
                    end else begin
                        load_next = 1'b1;
                    end
                end
            end

            // Payload bits are fed to the CRC as they leave the shift register.
            ST_DATA: begin
                if (bit_req) begin
                    crc_en = 1'b1;
                    if (!byte_end) begin
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (bytes_left_q == '0) begin
                        state_d   = ST_CRC;
                        bit_cnt_d = 4'd0;
                    end else begin
                        load_next = 1'b1;
                    end
                end
            end

            ST_CRC: begin
                if (bit_req) begin
                    if (bit_cnt_q == 4'd15) begin
                        state_d   = ST_EOP_SE0;
                        bit_cnt_d = 4'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end

            ST_EOP_SE0: begin
                if (bit_req) begin
                    if (bit_cnt_q[0]) begin
                        state_d   = ST_EOP_J;
                        bit_cnt_d = 4'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end

            ST_EOP_J: begin
                if (bit_req) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 4'd0;
                    shreg_d   = 8'h00;
                    done_d    = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An empty FIFO at a byte boundary is an underrun: skip CRC, go to EOP.
        if (load_next) begin
            bit_cnt_d = 4'd0;
            if (!fifo_empty) begin
                state_d      = ST_DATA;
                shreg_d      = fifo_rdata;
                fifo_rd      = 1'b1;
                bytes_left_d = bytes_left_q - LEN_W'(1);
            end else begin
                state_d = ST_EOP_SE0;
                error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            shreg_q      <= 8'h00;
            bit_cnt_q    <= 4'd0;
            pid_q        <= 4'd0;
            bytes_left_q <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            pid_q        <= pid_d;
            bytes_left_q <= bytes_left_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // CRC goes out inverted, MSB first, while the register is frozen.
    always_comb begin
        tx_bit = 1'b1;
        case (state_q)
            ST_SYNC, ST_PID, ST_DATA: tx_bit = shreg_q[0];
            ST_CRC:                   tx_bit = ~crc[~bit_cnt_q];
            default:                  tx_bit = 1'b1;
        endcase
    end

    assign tx_se0    = (state_q == ST_EOP_SE0);
    assign tx_active = (state_q != ST_IDLE);
    assign tx_done   = done_q;
    assign tx_error  = error_q;

endmodule

// File: tb/tb_usb_tx_ctrl.sv
// Self-checking bench for usb_tx_ctrl: a packet-level model builds the expected
// bit-time sequence per request and one compare process checks every cycle.
module tb_usb_tx_ctrl;
    import usb_pkg::*;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             tx_start = 1'b0;
    logic [3:0]       tx_pid = 4'd0;
    logic [LEN_W-1:0] tx_len = '0;
    logic [7:0]       fifo_rdata = 8'h00;
    logic             fifo_empty = 1'b1;
    logic             fifo_rd;
    logic             bit_req = 1'b0;
    logic             tx_bit;
    logic             tx_se0;
    logic             tx_active;
    logic             tx_done;
    logic             tx_error;

    usb_tx_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_start   (tx_start),
        .tx_pid     (tx_pid),
        .tx_len     (tx_len),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .bit_req    (bit_req),
        .tx_bit     (tx_bit),
        .tx_se0     (tx_se0),
        .tx_active  (tx_active),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    // Show-ahead payload FIFO; pops land just after the edge that saw fifo_rd.
    logic [7:0] fifoQ[$];
    logic       popNow;
    always @(posedge clk) begin
        popNow = fifo_rd;
        #1;
        if (popNow && fifoQ.size() > 0) void'(fifoQ.pop_front());
        fifo_empty = (fifoQ.size() == 0);
        fifo_rdata = (fifoQ.size() == 0) ? 8'h00 : fifoQ[0];
    end

    // ---------------- packet-level model ----------------
    bit symSe0[0:127];
    bit symBit[0:127];
    bit popMask[0:127];
    int nSyms    = 0;
    int symIdx   = 0;
    int errIdx   = -1;
    bit modelBusy = 1'b0;
    bit expDone   = 1'b0;
    bit expError  = 1'b0;

    function automatic logic [15:0] crcOfBytes(input logic [7:0] data[$]);
        logic [15:0] c = 16'hFFFF;
        logic fb;
        foreach (data[k]) begin
            for (int i = 0; i < 8; i++) begin
                fb = data[k][i] ^ c[15];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
        end
        return c;
    endfunction

    function automatic bit requestLegal(input logic [3:0] pid, input int len);
        bit hs = (pid == 4'b0010) || (pid == 4'b1010) || (pid == 4'b1110);
        bit dt = (pid == 4'b0011) || (pid == 4'b1011);
        return hs || (dt && len <= MAX_LEN);
    endfunction

    task automatic addSym(input bit se0, input bit b);
        symSe0[nSyms] = se0;
        symBit[nSyms] = b;
        nSyms++;
    endtask

    task automatic addByte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) addSym(1'b0, v[i]);
    endtask

    task automatic buildPacket(input logic [3:0] pid, input int len);
        logic [7:0]  payload[$];
        logic [15:0] c;
        int nLoad;
        nSyms  = 0;
        errIdx = -1;
        for (int i = 0; i < 128; i++) popMask[i] = 1'b0;
        addByte(8'h80);
        addByte({~pid, pid});
        if (pid == 4'b0011 || pid == 4'b1011) begin
            nLoad = (fifoQ.size() < len) ? fifoQ.size() : len;
            for (int k = 0; k < nLoad; k++) begin
                popMask[nSyms-1] = 1'b1;
                payload.push_back(fifoQ[k]);
                addByte(fifoQ[k]);
            end
            if (nLoad == len) begin
                c = crcOfBytes(payload);
                for (int i = 15; i >= 0; i--) addSym(1'b0, ~c[i]);
            end else begin
                errIdx = nSyms;
            end
        end
        addSym(1'b1, 1'b1);
        addSym(1'b1, 1'b1);
        addSym(1'b0, 1'b1);
    endtask

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            modelBusy = 1'b0;
            expDone   = 1'b0;
            expError  = 1'b0;
            symIdx    = 0;
        end else begin
            expDone  = 1'b0;
            expError = 1'b0;
            if (modelBusy) begin
                if (bit_req) begin
                    symIdx++;
                    if (symIdx == errIdx) expError = 1'b1;
                    if (symIdx == nSyms) begin
                        modelBusy = 1'b0;
                        expDone   = 1'b1;
                    end
                end
            end else if (tx_start) begin
                if (requestLegal(tx_pid, int'(tx_len))) begin
                    buildPacket(tx_pid, int'(tx_len));
                    modelBusy = 1'b1;
                    symIdx    = 0;
                end else begin
                    expError = 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int popTotal = 0;
    int errTotal = 0;
    always @(negedge clk) begin
        logic [5:0] expVec;
        logic [5:0] dutVec;
        expVec = {modelBusy,
                  modelBusy ? symSe0[symIdx] : 1'b0,
                  modelBusy ? symBit[symIdx] : 1'b1,
                  expDone, expError,
                  modelBusy && bit_req && popMask[symIdx]};
        dutVec = {tx_active, tx_se0, tx_se0 ? 1'b1 : tx_bit, tx_done, tx_error, fifo_rd};
        checkOutput("cycle {active,se0,bit,done,error,fifo_rd}", 32'(dutVec), 32'(expVec));
        checkOutput("fifo_rd while empty", 32'(fifo_rd && fifo_empty), 32'd0);
        popTotal += int'(fifo_rd);
        errTotal += int'(tx_error);
    end

    // ---------------- stimulus ----------------
    task automatic startPacket(input logic [3:0] pid, input int len, input bit immediate);
        if (!immediate) begin
            @(posedge clk);
            #2;
        end
        tx_start = 1'b1;
        tx_pid   = pid;
        tx_len   = LEN_W'(len);
        @(posedge clk);
        #2;
        tx_start = 1'b0;
    endtask

    task automatic applyStimulus(input int period, input int busyStartAt, output int reqs);
        int c = 0;
        reqs = 0;
        while (modelBusy && c < 2000) begin
            bit_req = ((c % period) == period - 1);
            if (bit_req) reqs++;
            tx_start = (c == busyStartAt);
            if (c == busyStartAt) begin
                tx_pid = 4'b0011;
                tx_len = '0;
            end
            @(posedge clk);
            #2;
            c++;
        end
        bit_req  = 1'b0;
        tx_start = 1'b0;
        if (c >= 2000) checkOutput("packet completion timeout", 32'(c), 32'd0);
    endtask

    function automatic logic [15:0] packSyms(input int start, input int count);
        logic [15:0] v = 16'h0000;
        for (int i = 0; i < count; i++) v = {v[14:0], symBit[start+i]};
        return v;
    endfunction

    initial begin
        int reqs;
        int pops0;
        int errs0;
        logic [7:0] noBytes[$];
        logic [7:0] zeroByte[$];
        zeroByte.push_back(8'h00);

        repeat (3) @(posedge clk);
        #2;
        n_rst = 1'b1;
        @(posedge clk);
        #2;
        checkOutput("reset outputs", 32'({tx_active, tx_se0, tx_bit, tx_done, tx_error, fifo_rd}), 32'b001000);
        checkOutput("crc of no bytes", 32'(crcOfBytes(noBytes)), 32'hFFFF);
        checkOutput("crc of 0x00", 32'(crcOfBytes(zeroByte)), 32'hFD02);

        $display("[TB] ACK handshake");
        pops0 = popTotal;
        startPacket(4'b0010, 0, 1'b0);
        checkOutput("ACK symbol count", 32'(nSyms), 32'd19);
        checkOutput("ACK sync+pid bits", 32'(packSyms(0, 16)), 32'b0000_0001_0100_1011);
        applyStimulus(4, -1, reqs);
        checkOutput("ACK bit_req count", 32'(reqs), 32'd19);
        checkOutput("ACK pops", 32'(popTotal - pops0), 32'd0);

        $display("[TB] DATA0 empty payload");
        pops0 = popTotal;
        startPacket(4'b0011, 0, 1'b0);
        checkOutput("DATA0 pid bits", 32'(packSyms(8, 8)), 32'b1100_0011);
        checkOutput("DATA0 crc bits", 32'(packSyms(16, 16)), 32'h0000);
        applyStimulus(3, -1, reqs);
        checkOutput("DATA0 len0 bit_req count", 32'(reqs), 32'd35);
        checkOutput("DATA0 len0 pops", 32'(popTotal - pops0), 32'd0);

        $display("[TB] DATA1 one zero byte");
        fifoQ.push_back(8'h00);
        repeat (2) @(posedge clk);
        #2;
        pops0 = popTotal;
        startPacket(4'b1011, 1, 1'b0);
        checkOutput("DATA1 crc bits", 32'(packSyms(24, 16)), 32'b0000_0010_1111_1101);
        applyStimulus(2, -1, reqs);
        checkOutput("DATA1 len1 bit_req count", 32'(reqs), 32'd43);
        checkOutput("DATA1 len1 pops", 32'(popTotal - pops0), 32'd1);

        $display("[TB] DATA0 underrun");
        fifoQ.push_back(8'hA5);
        repeat (2) @(posedge clk);
        #2;
        pops0 = popTotal;
        errs0 = errTotal;
        startPacket(4'b0011, 3, 1'b0);
        checkOutput("underrun error index", 32'(errIdx), 32'd24);
        applyStimulus(4, -1, reqs);
        checkOutput("underrun bit_req count", 32'(reqs), 32'd27);
        checkOutput("underrun pops", 32'(popTotal - pops0), 32'd1);
        checkOutput("underrun error pulses", 32'(errTotal - errs0), 32'd1);

        $display("[TB] DATA1 four bytes, bit_req every cycle");
        fifoQ.push_back(8'h01);
        fifoQ.push_back(8'h02);
        fifoQ.push_back(8'h80);
        fifoQ.push_back(8'hFF);
        repeat (2) @(posedge clk);
        #2;
        pops0 = popTotal;
        startPacket(4'b1011, 4, 1'b0);
        applyStimulus(1, -1, reqs);
        checkOutput("DATA1 len4 bit_req count", 32'(reqs), 32'd67);
        checkOutput("DATA1 len4 pops", 32'(popTotal - pops0), 32'd4);

        $display("[TB] DATA0 maximum length");
        for (int i = 0; i < 8; i++) fifoQ.push_back(8'(i * 37 + 5));
        repeat (2) @(posedge clk);
        #2;
        pops0 = popTotal;
        startPacket(4'b0011, 8, 1'b0);
        applyStimulus(2, -1, reqs);
        checkOutput("DATA0 len8 bit_req count", 32'(reqs), 32'd99);
        checkOutput("DATA0 len8 pops", 32'(popTotal - pops0), 32'd8);

        $display("[TB] illegal requests");
        errs0 = errTotal;
        startPacket(4'b0000, 0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        checkOutput("illegal pid stays idle", 32'(tx_active), 32'd0);
        startPacket(4'b0011, 9, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        startPacket(PID_IN, 0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        checkOutput("illegal error pulses", 32'(errTotal - errs0), 32'd3);

        $display("[TB] NAK ignores oversize length");
        startPacket(4'b1010, 9, 1'b0);
        applyStimulus(2, -1, reqs);
        checkOutput("NAK bit_req count", 32'(reqs), 32'd19);

        $display("[TB] back-to-back start in done cycle");
        startPacket(4'b1110, 0, 1'b1);
        checkOutput("STALL accepted in done cycle", 32'(tx_active), 32'd1);
        applyStimulus(3, -1, reqs);
        checkOutput("STALL bit_req count", 32'(reqs), 32'd19);

        $display("[TB] reset mid-payload");
        fifoQ.push_back(8'h11);
        fifoQ.push_back(8'h22);
        fifoQ.push_back(8'h33);
        repeat (2) @(posedge clk);
        #2;
        startPacket(4'b0011, 3, 1'b0);
        for (int c = 0; c < 40; c++) begin
            bit_req = (c % 2 == 1);
            @(posedge clk);
            #2;
        end
        bit_req = 1'b0;
        n_rst   = 1'b0;
        #1;
        checkOutput("outputs during reset", 32'({tx_active, tx_se0, tx_bit, tx_done, tx_error, fifo_rd}), 32'b001000);
        @(posedge clk);
        #2;
        fifoQ.delete();
        @(posedge clk);
        #2;
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        pops0 = popTotal;
        startPacket(4'b0010, 0, 1'b0);
        applyStimulus(2, 6, reqs);
        checkOutput("post-reset ACK bit_req count", 32'(reqs), 32'd19);
        checkOutput("post-reset ACK pops", 32'(popTotal - pops0), 32'd0);

        repeat (3) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/usb_tx_ctrl.md
Name: usb_tx_ctrl

Overview:
Transmit-side sequencer for the USB encryptor's device port. It is the counterpart of the receive control unit. On a start request it serialises SYNC, PID, optional payload bytes and CRC16, then EOP. The downstream NRZI/bit-stuff encoder paces it with one bit request per bit time. It issues ACK/NAK/STALL handshakes and DATA0/DATA1 packets, pulling payload bytes from a show-ahead byte FIFO.

Parameters:
MAX_LEN, 8, maximum payload bytes per DATA packet (matches the 64-bit receive data field).
LEN_W, $clog2(MAX_LEN+1), width of tx_len.

Ports:
clk  in  1  system clock
n_rst  in  1  reset, asynchronous, active-low
tx_start  in  1  one-cycle request to send a packet; sampled only in IDLE
tx_pid  in  4  PID nibble (ACK 0010, NAK 1010, STALL 1110, DATA0 0011, DATA1 1011)
tx_len  in  LEN_W  payload byte count, sampled with tx_start; ignored for handshakes
fifo_rdata  in  8  head byte of the payload FIFO, valid while fifo_empty=0 (show-ahead)
fifo_empty  in  1  payload FIFO empty
fifo_rd  out  1  one-cycle pop of the FIFO head
bit_req  in  1  one-cycle strobe from the encoder: current bit consumed, advance; held low during stuff bits
tx_bit  out  1  current logical bit to encode (valid while tx_se0=0)
tx_se0  out  1  drive SE0 (EOP)
tx_active  out  1  packet in progress (SYNC through EOP J bit)
tx_done  out  1  one-cycle pulse on return to IDLE after a completed or aborted packet
tx_error  out  1  one-cycle pulse: illegal PID, tx_len>MAX_LEN, or FIFO underrun

Behaviour:
- Reset (async) forces state IDLE. Outputs: tx_bit=1, tx_se0=0, tx_active=0, tx_done=0, tx_error=0, fifo_rd=0. Shift register and counters are cleared. Reset mid-packet truncates immediately with no EOP.
- States: IDLE, SYNC, PID, DATA, CRC, EOP_SE0, EOP_J.
- Every field goes out LSB first from an 8-bit shift register `shreg`. tx_bit = shreg[0] in SYNC/PID/DATA. `bit_cnt` is 3 bits; in CRC it is a 4-bit count.
- Bits advance only on a bit_req cycle: shift right, bit_cnt+1. With no bit_req, the state holds.
- IDLE with tx_start:
  - Legal PID and tx_len<=MAX_LEN: the next cycle is SYNC with shreg=8'h80, bit_cnt=0, tx_active=1. Latch pid and len; set bytes_left=len.
  - Otherwise: tx_error pulses next cycle and the block stays IDLE.
- tx_start outside IDLE is ignored.
- SYNC, bit 7 consumed: load shreg={~pid,pid}, go to PID. Clear CRC to 16'hFFFF.
- PID, bit 7 consumed:
  - Handshake PID: go to EOP_SE0.
  - DATA PID with bytes_left=0: go to CRC.
  - DATA PID with bytes_left>0 and fifo_empty=0: load shreg=fifo_rdata, pulse fifo_rd in the same cycle, bytes_left-1, go to DATA.
  - DATA PID with bytes_left>0 and fifo_empty=1: underrun.
- DATA:
  - Each consumed bit feeds the CRC.
  - On bit 7: if bytes_left>0, load the next byte as above (underrun check identical); else go to CRC.
- CRC:
  - Update per data bit: fb=bit^crc[15]; crc={crc[14:0],1'b0}^(fb?16'h8005:0).
  - Transmit ~crc[15] first down to ~crc[0], 16 bits.
  - After the 16th bit_req, go to EOP_SE0.
- Underrun: tx_error pulses, go directly to EOP_SE0 (CRC omitted; the host discards the packet).
- EOP_SE0: tx_se0=1 for two bit_req, then EOP_J.
- EOP_J: tx_se0=0, tx_bit=1 for one bit_req, then IDLE with tx_done pulsed in the IDLE-entry cycle and tx_active=0.
- fifo_rd is never asserted while fifo_empty=1. There are exactly len pops per complete DATA packet.
- tx_start and tx_done in the same cycle: tx_start is accepted, because the state is already IDLE.

Decomposition:
- Package usb_pkg holds:
  - PID constants (PID_ACK, PID_NAK, PID_STALL, PID_DATA0, PID_DATA1, PID_OUT, PID_IN);
  - SYNC_BYTE=8'h80;
  - CRC16_POLY=16'h8005, CRC16_INIT=16'hFFFF;
  - the tx_state_t enum.
- Sub-module crc16_gen (serial CRC16) has ports clk, n_rst, clear, enable, din, crc[15:0]. The receive side reuses it for checking.

Test Plan:
- ACK (tx_pid=0010), bit_req every 4 cycles -> tx_bit sequence 0000000 1 then 0100 1011, then 2 bit times SE0, 1 J; tx_done after 19 bit_req; fifo_rd never asserted.
- DATA0, tx_len=0 -> bits SYNC, 1100 0011 (PID C3 LSB-first), 16 zeros (CRC 0x0000), EOP; 35 bit_req total.
- DATA1, tx_len=1, FIFO holds 8'h00 -> payload 8 zeros, CRC bits 0000 0010 1111 1101 (~crc=0x02FD, MSB first); exactly one fifo_rd.
- DATA0, tx_len=3, FIFO holds 1 byte -> fifo_rd once, tx_error pulse at the second byte load, SE0 on the next bit time, tx_done after J.
- Illegal PID 0000 or tx_len=9 -> tx_error pulse, tx_active stays 0, no bit activity.
- n_rst low mid-DATA, then tx_start with ACK -> all outputs at reset values immediately; the next packet is correct from SYNC. A second tx_start during the busy period has no effect.
